// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/debug master, the arbiter and dmem.
// The arbiter uses the slave view; the masters and memory use the master view.
interface dmem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dma_rdata, dma_ack,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dma_rdata, dma_ack,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage has priority, a starvation
// counter forces bounded DMA bursts during which a requesting CPU is stalled.
module dmem_port_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
);

  localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM - 1);
  localparam logic [BW-1:0] BURST_TOP  = BW'(MAX_BURST - 1);

  typedef enum logic {CPU_PRI, DMA_BURST} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          gnt_cpu, gnt_dma;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CPU_PRI;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // Grant is purely combinational so the memory sees the winner in the same cycle.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    burst_nxt  = burst_cnt;
    gnt_cpu    = 1'b0;
    gnt_dma    = 1'b0;
    if (!rst) begin
      case (state)
        CPU_PRI: begin
          if (bus.cpu_req) begin
            gnt_cpu = 1'b1;
            if (bus.dma_req) begin
              if (starve_cnt == STARVE_TOP) begin
                state_nxt  = DMA_BURST;
                starve_nxt = '0;
                burst_nxt  = '0;
              end else begin
                starve_nxt = starve_cnt + 1'b1;
              end
            end
          end else if (bus.dma_req) begin
            gnt_dma    = 1'b1;
            starve_nxt = '0;
          end
        end
        DMA_BURST: begin
          if (bus.dma_req) begin
            gnt_dma = 1'b1;
            if (burst_cnt == BURST_TOP) begin
              state_nxt = CPU_PRI;
              burst_nxt = '0;
            end else begin
              burst_nxt = burst_cnt + 1'b1;
            end
          end else begin
            // DMA gave up early: hand the port straight back to the CPU.
            gnt_cpu   = bus.cpu_req;
            state_nxt = CPU_PRI;
          end
        end
        default: state_nxt = CPU_PRI;
      endcase
    end
  end

  assign bus.cpu_stall = bus.cpu_req & gnt_dma;
  assign bus.dma_ack   = gnt_dma;
  assign bus.mem_we    = gnt_dma ? bus.dma_we : (gnt_cpu & bus.cpu_we);
  assign bus.mem_addr  = gnt_dma ? bus.dma_addr : bus.cpu_addr;
  assign bus.mem_wdata = gnt_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: two arbiters (default and 1/1 limits) share one stimulus
// stream; a cycle-level reference model predicts each cycle's outputs.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if i0();
  dmem_port_arbiter_if i1();

  dmem_port_arbiter #(.STARVE_LIM(4), .MAX_BURST(4)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  dmem_port_arbiter #(.STARVE_LIM(1), .MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

  logic [31:0] dev0 [64];
  logic [31:0] dev1 [64];
  assign i0.mem_rdata = dev0[i0.mem_addr[7:2]];
  assign i1.mem_rdata = dev1[i1.mem_addr[7:2]];
  always @(posedge clk) begin
    if (i0.mem_we) dev0[i0.mem_addr[7:2]] <= i0.mem_wdata;
    if (i1.mem_we) dev1[i1.mem_addr[7:2]] <= i1.mem_wdata;
  end

  typedef struct {
    bit          chk_mux;
    bit          stall;
    bit          ack;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_crd;
    logic [31:0] crd;
    bit          chk_drd;
    logic [31:0] drd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          denied[2];
  int          burst_left[2];
  int          lim_s[2] = '{4, 1};
  int          lim_b[2] = '{4, 1};
  logic [31:0] mm0 [64];
  logic [31:0] mm1 [64];
  bit          last_ack0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: one memory access per cycle, CPU first unless a forced burst
  // (after lim_s consecutive denials) owes the DMA up to lim_b words.
  task automatic step(input bit r, input bit cr, input bit cw, input logic [31:0] ca,
                      input logic [31:0] cd, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dd);
    exp_t e;
    bit   gc, gd;
    @(posedge clk);
    #1;
    rst = r;
    i0.cpu_req = cr; i0.cpu_we = cw; i0.cpu_addr = ca; i0.cpu_wdata = cd;
    i0.dma_req = dr; i0.dma_we = dw; i0.dma_addr = da; i0.dma_wdata = dd;
    i1.cpu_req = cr; i1.cpu_we = cw; i1.cpu_addr = ca; i1.cpu_wdata = cd;
    i1.dma_req = dr; i1.dma_we = dw; i1.dma_addr = da; i1.dma_wdata = dd;
    for (int k = 0; k < 2; k++) begin
      gc = 1'b0;
      gd = 1'b0;
      if (r) begin
        denied[k]     = 0;
        burst_left[k] = 0;
      end else if (burst_left[k] > 0) begin
        if (dr) begin
          gd = 1'b1;
          burst_left[k]--;
        end else begin
          gc = cr;
          burst_left[k] = 0;
        end
      end else if (cr) begin
        gc = 1'b1;
        if (dr) begin
          denied[k]++;
          if (denied[k] == lim_s[k]) begin
            burst_left[k] = lim_b[k];
            denied[k]     = 0;
          end
        end
      end else if (dr) begin
        gd = 1'b1;
        denied[k] = 0;
      end
      e.chk_mux = !r;
      e.stall   = cr & gd;
      e.ack     = gd;
      e.we      = gd ? dw : (gc & cw);
      e.addr    = gd ? da : ca;
      e.wdata   = gd ? dd : cd;
      e.chk_crd = gc & !cw;
      e.chk_drd = gd & !dw;
      if (k == 0) begin
        e.crd = mm0[ca[7:2]];
        e.drd = mm0[da[7:2]];
        if (e.we) mm0[e.addr[7:2]] = e.wdata;
        q0.push_back(e);
        last_ack0 = gd;
      end else begin
        e.crd = mm1[ca[7:2]];
        e.drd = mm1[da[7:2]];
        if (e.we) mm1[e.addr[7:2]] = e.wdata;
        q1.push_back(e);
      end
    end
  endtask

  task automatic check(input string tag, input exp_t e, input bit stall, input bit ack,
                       input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] crd, input logic [31:0] drd);
    cmp({tag, ".cpu_stall"}, 32'(stall), 32'(e.stall));
    cmp({tag, ".dma_ack"}, 32'(ack), 32'(e.ack));
    cmp({tag, ".mem_we"}, 32'(we), 32'(e.we));
    if (e.chk_mux) begin
      cmp({tag, ".mem_addr"}, addr, e.addr);
      cmp({tag, ".mem_wdata"}, wdata, e.wdata);
    end
    if (e.chk_crd) cmp({tag, ".cpu_rdata"}, crd, e.crd);
    if (e.chk_drd) cmp({tag, ".dma_rdata"}, drd, e.drd);
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0)
      check("lim4", q0.pop_front(), i0.cpu_stall, i0.dma_ack, i0.mem_we, i0.mem_addr,
            i0.mem_wdata, i0.cpu_rdata, i0.dma_rdata);
    if (q1.size() > 0)
      check("lim1", q1.pop_front(), i1.cpu_stall, i1.dma_ack, i1.mem_we, i1.mem_addr,
            i1.mem_wdata, i1.cpu_rdata, i1.dma_rdata);
  end

  initial begin
    bit          r, cr, cw, dpend, dw_r;
    logic [31:0] ca, cd, da_r, dd_r;
    for (int i = 0; i < 64; i++) begin
      dev0[i] = '0; dev1[i] = '0; mm0[i] = '0; mm1[i] = '0;
    end
    denied = '{0, 0};
    burst_left = '{0, 0};
    i0.cpu_req = 0; i0.cpu_we = 0; i0.cpu_addr = '0; i0.cpu_wdata = '0;
    i0.dma_req = 0; i0.dma_we = 0; i0.dma_addr = '0; i0.dma_wdata = '0;
    i1.cpu_req = 0; i1.cpu_we = 0; i1.cpu_addr = '0; i1.cpu_wdata = '0;
    i1.dma_req = 0; i1.dma_we = 0; i1.dma_addr = '0; i1.dma_wdata = '0;

    // Reset with both masters requesting: nothing may be granted.
    repeat (3) step(1, 1, 1, 32'h10, 32'hDEAD0000, 1, 1, 32'h30, 32'hBEEF0000);

    // CPU-only store then load.
    step(0, 1, 1, 32'h10, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);

    // DMA-only writes, then a DMA read-back and a CPU read of DMA data.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20 + 32'(4 * i), 32'h1100_0000 + 32'(i));
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0);
    step(0, 1, 0, 32'h28, 32'h0, 0, 0, 32'h0, 32'h0);

    // Continuous contention: starvation bursts.
    da_r = 32'h40;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 32'h10, 32'h0, 1, 1, da_r, da_r ^ 32'h5A5A0000);
      if (last_ack0) da_r += 4;
    end

    // Early DMA drop after the second burst ack.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 32'h20, 32'h0, 1, 1, da_r, da_r ^ 32'h5A5A0000);
      if (last_ack0) da_r += 4;
    end
    step(0, 1, 1, 32'h2C, 32'h77777777, 0, 0, 32'h0, 32'h0);

    // Reset after the first burst ack, then CPU must win at once.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'h2C, 32'h0, 1, 1, da_r, da_r ^ 32'h5A5A0000);
      if (last_ack0) da_r += 4;
    end
    step(1, 1, 0, 32'h2C, 32'h0, 1, 1, da_r, 32'h0);
    step(0, 1, 0, 32'h2C, 32'h0, 1, 0, da_r, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Random traffic; the DMA request is held until acknowledged.
    dpend = 0; dw_r = 0; da_r = '0; dd_r = '0;
    repeat (400) begin
      r  = ($urandom_range(0, 60) == 0);
      cr = ($urandom_range(0, 3) != 0);
      cw = $urandom_range(0, 1);
      ca = 32'($urandom_range(0, 63)) << 2;
      cd = $urandom;
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1;
        dw_r  = $urandom_range(0, 1);
        da_r  = 32'($urandom_range(0, 63)) << 2;
        dd_r  = $urandom;
      end
      step(r, cr, cw, ca, cd, dpend, dw_r, da_r, dd_r);
      if (last_ack0 || r) dpend = 0;
    end

    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
